// File: rtl/freq_buffer_ctrl.sv
// Ping-pong write/read controller for a two-bank frequency-frame buffer.
// Owns bank ownership, per-bank frame length, write addressing and ready-latency-1 read-out framing.
module freq_buffer_ctrl #(
  parameter int  TOT_SIZE = 2048,
  localparam int ADDR_W   = $clog2(TOT_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic              sink_valid,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              source_ready,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  output logic [1:0]        bank_full,
  output logic              err_overflow,
  output logic              err_drop
);

  localparam int                LEN_W    = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(TOT_SIZE);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_READ}         r_state_t;

  w_state_t          w_state, w_state_n;
  r_state_t          r_state, r_state_n;

  logic              w_bank_q, w_bank_n;
  logic [LEN_W-1:0]  w_cnt_q, w_cnt_n;        // entries written so far in the current frame
  logic [LEN_W-1:0]  len_q [2];
  logic [1:0]        bank_full_q, bank_full_n;
  logic [1:0]        set_full, release_vec, free_vec;
  logic              older_q, older_n;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              rd_en_c, rd_last, release_en, oldest_bank;
  logic              have_free, free_bank;
  logic              wr_en_c, wr_bank_c, ovf_c, drop_c, fr_done;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [LEN_W-1:0]  fr_len;

  // Read-side decode; the final read releases its bank to the writer in the same cycle.
  always_comb begin
    rd_en_c     = (r_state == R_READ) && source_ready;
    rd_last     = ({1'b0, rd_addr_q} == (len_q[rd_bank_q] - LEN_W'(1)));
    release_en  = rd_en_c && rd_last;
    release_vec = '0;
    if (release_en) release_vec[rd_bank_q] = 1'b1;
    free_vec    = ~bank_full_q | release_vec;
    have_free   = |free_vec;
    free_bank   = ~free_vec[0];
    oldest_bank = (bank_full_q == 2'b11) ? older_q : bank_full_q[1];
  end

  // Write FSM outputs (combinational from inputs and write state)
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    wr_en_c   = 1'b0;
    wr_bank_c = w_bank_q;
    wr_addr_c = '0;
    ovf_c     = 1'b0;
    drop_c    = 1'b0;
    fr_done   = 1'b0;
    fr_len    = '0;
    if (sink_valid) begin
      if (sink_sop && (w_state != W_FILL)) begin
        if (have_free) begin
          wr_en_c   = 1'b1;
          wr_bank_c = free_bank;
          if (sink_eop) begin
            fr_done = 1'b1;
            fr_len  = LEN_W'(1);
          end
        end else begin
          drop_c = 1'b1;
        end
      end else if (w_state == W_FILL) begin
        if (sink_sop) begin
          wr_en_c = 1'b1;
          if (sink_eop) begin
            fr_done = 1'b1;
            fr_len  = LEN_W'(1);
          end
        end else if (w_cnt_q < FULL_LEN) begin
          wr_en_c   = 1'b1;
          wr_addr_c = w_cnt_q[ADDR_W-1:0];
          if (sink_eop) begin
            fr_done = 1'b1;
            fr_len  = w_cnt_q + LEN_W'(1);
          end
        end else begin
          ovf_c = 1'b1;
          if (sink_eop) begin
            fr_done = 1'b1;
            fr_len  = FULL_LEN;
          end
        end
      end
    end
  end

  // Write FSM next state and fill bookkeeping
  always_comb begin
    w_state_n = w_state;
    w_bank_n  = w_bank_q;
    w_cnt_n   = w_cnt_q;
    if (wr_en_c) begin
      w_bank_n = wr_bank_c;
      w_cnt_n  = {1'b0, wr_addr_c} + LEN_W'(1);
    end
    if (sink_valid) begin
      if (sink_eop)
        w_state_n = W_IDLE;
      else if (sink_sop)
        w_state_n = ((w_state == W_FILL) || have_free) ? W_FILL : W_DROP;
    end
  end

  // Bank ownership: a completion wins over a same-cycle release of the same bank.
  always_comb begin
    set_full = '0;
    if (fr_done) set_full[wr_bank_c] = 1'b1;
    bank_full_n = (bank_full_q & ~release_vec) | set_full;
    older_n     = older_q;
    if (fr_done)
      older_n = (bank_full_q[!wr_bank_c] && !release_vec[!wr_bank_c]) ? !wr_bank_c : wr_bank_c;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      w_state     <= W_IDLE;
      w_bank_q    <= 1'b0;
      w_cnt_q     <= '0;
      bank_full_q <= '0;
      older_q     <= 1'b0;
    end else begin
      w_state     <= w_state_n;
      w_bank_q    <= w_bank_n;
      w_cnt_q     <= w_cnt_n;
      bank_full_q <= bank_full_n;
      older_q     <= older_n;
    end
  end

  // NOTE: frame lengths are not reset; a length is always written before its bank_full bit rises.
  always_ff @(posedge clk) begin
    if (fr_done) len_q[wr_bank_c] <= fr_len;
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_n;
  end

  // Read FSM next state
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (|bank_full_q) r_state_n = R_READ;
      R_READ:  if (release_en)   r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read addressing and output framing, one cycle behind the memory read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else begin
      if (r_state == R_IDLE) begin
        rd_addr_q <= '0;
        if (|bank_full_q) rd_bank_q <= oldest_bank;
      end else if (rd_en_c) begin
        rd_addr_q <= rd_last ? '0 : rd_addr_q + ADDR_W'(1);
      end
      source_valid <= rd_en_c;
      source_sop   <= rd_en_c && (rd_addr_q == '0);
      source_eop   <= release_en;
    end
  end

  assign wr_en        = wr_en_c & ~reset;
  assign wr_bank      = wr_bank_c & ~reset;
  assign wr_addr      = wr_addr_c & {ADDR_W{~reset}};
  assign err_overflow = ovf_c & ~reset;
  assign err_drop     = drop_c & ~reset;
  assign rd_en        = rd_en_c & ~reset;
  assign rd_bank      = rd_bank_q;
  assign rd_addr      = rd_addr_q;
  assign bank_full    = bank_full_q;

endmodule
